// File: rtl/conv_window_sequencer.sv
// Scan controller for the 3x3 sliding-window line buffer: walks the zero-padded frame.
// Optional build macro SEQ_STRIDE2_EN adds stride-2 window qualification.
module conv_window_sequencer #(
  parameter int BITSIZE = 14,
  parameter int MAXN    = 112
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [6:0]         layer_size,
  input  logic               stride,
  input  logic [BITSIZE-1:0] px_in,
  input  logic               px_valid,
  output logic               px_ready,
  output logic [BITSIZE-1:0] lb_pixel,
  output logic               lb_in_valid,
  output logic               lb_zero_buffer,
  output logic               lb_wr_en,
  output logic [6:0]         lb_layer_fifosize,
  output logic               lb_end_of_layer,
  output logic               window_valid,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);
  localparam int PW = $clog2(MAXN + 2);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FLUSH, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] r_q, r_d, c_q, c_d;
  logic [6:0]    n_q, n_d;
  logic          cfg_err_q, cfg_err_d;
  logic          win_q, win_d;
  logic [PW-1:0] last;
  logic          size_ok, pad, shift, on_grid;

  assign last    = PW'(n_q) + PW'(1);
  assign size_ok = (layer_size == 7'd112) || (layer_size == 7'd56) || (layer_size == 7'd26);
  assign pad     = (r_q == '0) || (r_q == last) || (c_q == '0) || (c_q == last);

`ifdef SEQ_STRIDE2_EN
  logic stride_q, stride_d;
  assign stride_d = (state_q == S_IDLE && start && size_ok) ? stride : stride_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stride_q <= 1'b0;
    else      stride_q <= stride_d;
  end
  // Stride-2 windows are those whose completing shift lands on an even row and column
  assign on_grid = ~stride_q | (~r_q[0] & ~c_q[0]);
`else
  logic unused_stride;
  assign unused_stride = stride;
  assign on_grid       = 1'b1;
`endif

  // A shift at (r,c) with r,c >= 2 completes the window centred at (r-1,c-1)
  assign win_d = shift && (r_q >= PW'(2)) && (c_q >= PW'(2)) && on_grid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      r_q       <= '0;
      c_q       <= '0;
      n_q       <= '0;
      cfg_err_q <= 1'b0;
      win_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      c_q       <= c_d;
      n_q       <= n_d;
      cfg_err_q <= cfg_err_d;
      win_q     <= win_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    r_d             = r_q;
    c_d             = c_q;
    n_d             = n_q;
    cfg_err_d       = cfg_err_q;
    shift           = 1'b0;
    px_ready        = 1'b0;
    lb_wr_en        = 1'b0;
    lb_in_valid     = 1'b0;
    lb_zero_buffer  = 1'b0;
    lb_pixel        = '0;
    lb_end_of_layer = 1'b0;
    done            = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          r_d = '0;
          c_d = '0;
          if (size_ok) begin
            state_d   = S_SCAN;
            n_d       = layer_size;
            cfg_err_d = 1'b0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_SCAN: begin
        if (pad) begin
          lb_wr_en       = 1'b1;
          lb_zero_buffer = 1'b1;
          shift          = 1'b1;
        end else begin
          // Ready depends only on position so upstream never sees a valid->ready loop
          px_ready = 1'b1;
          if (px_valid) begin
            lb_wr_en    = 1'b1;
            lb_in_valid = 1'b1;
            lb_pixel    = px_in;
            shift       = 1'b1;
          end
        end
        if (shift) begin
          if (c_q == last) begin
            c_d = '0;
            if (r_q == last) begin
              r_d     = '0;
              state_d = S_FLUSH;
            end else begin
              r_d = r_q + PW'(1);
            end
          end else begin
            c_d = c_q + PW'(1);
          end
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE: begin
        lb_end_of_layer = 1'b1;
        done            = 1'b1;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy              = (state_q != S_IDLE);
  assign window_valid      = win_q;
  assign cfg_err           = cfg_err_q;
  assign lb_layer_fifosize = n_q;

endmodule

// File: doc/conv_window_sequencer.md
# conv_window_sequencer

Scan controller for the 3x3 sliding-window line buffer in the depthwise-convolution path. It walks the zero-padded (N+2)x(N+2) frame in row-major order and pulls interior pixels from the upstream activation stream. It drives the line buffer's pixel, shift, zero-insert, layer-size and clear inputs, and raises `window_valid` only for windows whose centre lies on the configured stride grid, replacing the line buffer's count-based `data_valid`.

## Interface
- `BITSIZE`, 14, pixel width (Q7 fixed point, passed through unmodified)
- `MAXN`, 112, largest supported feature-map edge; sets counter widths
- `clk` in 1: rising-edge clock
- `rst` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle layer start pulse, honoured only in IDLE
- `layer_size` in 7: edge N; legal values 112, 56, 26
- `stride` in 1: 0 = stride 1, 1 = stride 2
- `px_in` in BITSIZE: upstream pixel
- `px_valid` in 1: upstream pixel available
- `px_ready` out 1: pixel consumed this cycle
- `lb_pixel` out BITSIZE: line-buffer pixel input
- `lb_in_valid` out 1: load `lb_pixel` this shift
- `lb_zero_buffer` out 1: load zero (padding) this shift
- `lb_wr_en` out 1: line-buffer shift enable
- `lb_layer_fifosize` out 7: latched N
- `lb_end_of_layer` out 1: one-cycle line-buffer clear
- `window_valid` out 1: line-buffer window is a legal output this cycle
- `busy` out 1: not in IDLE
- `done` out 1: one-cycle completion pulse
- `cfg_err` out 1: sticky illegal-`layer_size` flag

## Operation
- States:
  - IDLE: on `start`, latch `layer_size` and `stride`; clear row r and column c.
    - Legal size: go to SCAN and clear `cfg_err`.
    - Illegal size: stay in IDLE and set `cfg_err`.
  - SCAN: advance through positions (r,c), r,c in 0..N+1.
  - FLUSH: one cycle after the last shift.
  - DONE: pulse `lb_end_of_layer` and `done`, then return to IDLE.
- Padding position (r==0, r==N+1, c==0 or c==N+1):
  - `lb_wr_en`=1, `lb_zero_buffer`=1, `lb_in_valid`=0.
  - Position advances unconditionally; `px_ready`=0.
- Interior position:
  - `px_ready`=1 in SCAN.
  - When `px_valid`=1: `lb_wr_en`=1, `lb_in_valid`=1, `lb_pixel`=`px_in`, position advances.
  - When `px_valid`=0: `lb_wr_en`=0, position held, no shift (stall).
- Advance rule: c increments; at c==N+1, c wraps to 0 and r increments. The shift at (N+1,N+1) moves the FSM to FLUSH.
- Window candidate: a shift at (r,c) with r>=2 and c>=2 completes the window centred at (r-1,c-1).
  - Stride 1: every candidate is legal.
  - Stride 2: legal only when r and c are both even.
- `lb_pixel` = 0 whenever `lb_in_valid`=0.
- `lb_layer_fifosize` holds the latched N from start until the next legal start.
- Window counts per layer:
  - Stride 1: N*N.
  - Stride 2: (N/2)^2, i.e. 3136, 784 or 169.

## Timing
- Reset values:
  - State is IDLE; r=c=0.
  - All 1-bit outputs are 0, including `cfg_err`.
  - `lb_pixel`=0 and `lb_layer_fifosize`=0.
- Latencies:
  - The first SCAN shift occurs the cycle after `start`.
  - `window_valid` asserts exactly one cycle after the qualifying shift, aligned with the registered line-buffer contents. It never asserts during stall cycles.
- Handshake:
  - The pixel transfer is `px_valid & px_ready`, applied in the same cycle.
  - `px_ready` is combinational on state and position only, never on `px_valid`.
- Simultaneous events:
  - `start` during SCAN, FLUSH or DONE is ignored.
  - The last shift, FLUSH and DONE occupy three consecutive cycles.
  - `start` may assert in the DONE cycle; it is acted on only from IDLE one cycle later.
- Reset mid-layer: return to IDLE immediately with all outputs at reset values. The line buffer is cleared by its own reset.

## Configuration
- `SEQ_STRIDE2_EN` defined: the `stride` input is latched and stride-2 qualification applies.
- `SEQ_STRIDE2_EN` undefined:
  - `stride` is ignored and treated as 0.
  - The parity logic is not built.
  - Every candidate window is legal.

## Test plan
- N=26, stride 1, `px_valid` held high, `start` at cycle 0:
  - Exactly 784 `lb_wr_en` cycles (cycles 1..784) and 676 `px_ready` transfers.
  - 676 `window_valid` pulses, the first at cycle 60.
  - `lb_end_of_layer` and `done` at cycle 786.
- N=56, stride 2: 784 `window_valid` pulses. Every pulse follows a shift with r and c even. No pulse follows a shift in row 0, row 1, column 0 or column 1.
- N=26, `px_valid` low for 5 cycles at interior position (5,7):
  - Position holds and `lb_wr_en`=0 for those 5 cycles.
  - Totals are unchanged; `done` slips by exactly 5 cycles.
- `start` with `layer_size`=40: FSM stays in IDLE and `cfg_err`=1. A following `start` with 112 clears `cfg_err` and the scan runs 114*114=12996 shifts.
- `rst` low mid-SCAN at position (10,3): all outputs 0 within the same cycle. A new `start` then rescans from (0,0).
- `start` pulsed during SCAN and during DONE: no restart and no count change. A `start` at DONE+1 begins a new layer normally.
